// File: rtl/bcd2bin_16.sv
// bcd2bin_16 -- sequential 5-digit BCD to 16-bit binary converter using the
// reverse double-dabble algorithm (one shift/correct step per clock).
//
// Ports:
//   clk            system clock, all state changes on rising edge
//   rst_n          asynchronous active-low reset
//   start          conversion request, sampled while idle
//   BCD_0..BCD_4   BCD digits, BCD_0 least significant
//   B              16-bit binary result, held until the next completion
//   busy           high while a conversion is in progress
//   done           one-cycle completion pulse
//   err            error flag, valid with done, held until next acceptance
//
// Optional build macro: BCD2BIN_CHECK_EN enables digit-validity and
// range (> 65535) checking. Without it err is constant 0 and the result is
// the low 16 bits of the weighted digit sum.
//
// Latency: start accepted at edge k gives done/B after edge k+17.

module bcd2bin_16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  BCD_0,
  input  logic [3:0]  BCD_1,
  input  logic [3:0]  BCD_2,
  input  logic [3:0]  BCD_3,
  input  logic [3:0]  BCD_4,
  output logic [15:0] B,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] FIN   = 2'd2;

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic [19:0] bcd_q;
  logic [15:0] sh_q;
  logic [19:0] bcd_in;
  logic [35:0] shifted;
  logic [19:0] bcd_adj;

  assign bcd_in = {BCD_4, BCD_3, BCD_2, BCD_1, BCD_0};

  // One reverse double-dabble step: a digit whose bit 3 was filled from the
  // digit above received +8 for a half-ten that is really worth +5.
  always_comb begin
    shifted = {bcd_q, sh_q} >> 1;
    bcd_adj = shifted[35:16];
    for (int unsigned i = 0; i < 5; i++) begin
      if (shifted[16 + 4*i + 3]) begin
        bcd_adj[4*i +: 4] = shifted[16 + 4*i +: 4] - 4'd3;
      end
    end
  end

`ifdef BCD2BIN_CHECK_EN
  logic bad_in;
  logic err_q;

  always_comb begin
    bad_in = 1'b0;
    for (int unsigned i = 0; i < 5; i++) begin
      if (bcd_in[4*i +: 4] > 4'd9) begin
        bad_in = 1'b1;
      end
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      bcd_q <= '0;
      sh_q  <= '0;
      B     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
`ifdef BCD2BIN_CHECK_EN
      err_q <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            bcd_q <= bcd_in;
            sh_q  <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
`ifdef BCD2BIN_CHECK_EN
            err_q <= 1'b0;
            state <= bad_in ? FIN : SHIFT;
`else
            state <= SHIFT;
`endif
          end
        end
        SHIFT: begin
          bcd_q <= bcd_adj;
          sh_q  <= shifted[15:0];
          cnt   <= cnt + 4'd1;
          if (cnt == 4'd15) begin
            state <= FIN;
          end
        end
        FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
`ifdef BCD2BIN_CHECK_EN
          // An invalid digit skips SHIFT, so bcd_q still holds the nonzero
          // input here: the residue test covers both error cases.
          if (bcd_q != '0) begin
            B     <= '0;
            err_q <= 1'b1;
          end else begin
            B <= sh_q;
          end
`else
          B <= sh_q;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/bcd2bin_16.md
BCD2BIN_16 -- requirements
Module: bcd2bin_16

Interface
REQ-001 Parameters SHALL be none; widths are fixed at 5 BCD digits in and 16 binary bits out.
REQ-002 clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  conversion request; sampled on a rising edge of clk while idle.
REQ-005 BCD_0..BCD_4  input  4 each  BCD digits, least significant (BCD_0) to most significant (BCD_4).
REQ-006 B  output  16  binary result; registered, held until the next completion.
REQ-007 busy  output  1  high while a conversion is in progress.
REQ-008 done  output  1  one-cycle completion pulse.
REQ-009 err  output  1  error flag; valid while done is high, held until the next acceptance.

Function
REQ-010 States SHALL be IDLE, SHIFT and FIN.
- IDLE: waits for start.
- SHIFT: runs 16 iterations, counted by a 4-bit iteration counter.
- FIN: completion.
REQ-011 On an edge where state is IDLE and start=1, the block SHALL:
- capture the 5 digits into a 20-bit BCD register;
- clear a 16-bit shift register;
- clear err;
- enter SHIFT with counter=0;
- drive busy=1 from this edge.
REQ-012 Each SHIFT edge SHALL perform one reverse double-dabble step:
- shift {BCD register, shift register} right one bit as a single 36-bit value;
- then subtract 3 from every 4-bit BCD digit whose shifted value is >= 8.
REQ-013 After the 16th SHIFT edge, the block SHALL enter FIN.
REQ-014 On the FIN edge, the block SHALL:
- load B from the shift register;
- assert done for exactly one cycle;
- drive busy=0;
- return to IDLE.
REQ-015 Latency SHALL be 17 clocks: start sampled at edge k gives B valid and done=1 after edge k+17.
REQ-016 start SHALL be ignored while busy=1; it SHALL be accepted again from edge k+18 onward.
REQ-017 start held continuously high SHALL produce back-to-back conversions every 18 clocks.
REQ-018 Input digits SHALL be sampled only at acceptance; later input changes SHALL NOT affect the running conversion.
REQ-019 B SHALL change only on the FIN edge (or on reset), never mid-conversion.

Reset
REQ-020 rst_n=0 SHALL immediately force the following, regardless of clk:
- state=IDLE, counter=0;
- B=16'h0000;
- busy=0, done=0, err=0.
REQ-021 A reset asserted mid-conversion SHALL abort it without producing a done pulse.
REQ-022 After reset release, the first start SHALL be accepted on the first rising edge where rst_n=1 and start=1.

Configuration
REQ-023 Macro BCD2BIN_CHECK_EN SHALL enable input and range checking.
REQ-024 With BCD2BIN_CHECK_EN defined, any captured digit > 9 at acceptance SHALL:
- skip SHIFT and go directly to FIN;
- at the next edge, give B=0, err=1, done=1;
- drive busy=1 for that one cycle.
REQ-025 With BCD2BIN_CHECK_EN defined, a residual BCD register that is nonzero after 16 iterations (input > 65535) SHALL give B=0 and err=1 on the FIN edge.
REQ-026 Without BCD2BIN_CHECK_EN:
- err SHALL be tied to 0;
- invalid digits SHALL be converted through the normal 16 iterations without special handling;
- B SHALL be the low 16 bits of the result (input mod 65536 for valid BCD).

Verification
REQ-027 Digits 1,2,3,4,5 (value 12345) with start at edge k -> B=16'h3039, done=1 after edge k+17, err=0, busy high for 17 cycles.
REQ-028 Value 65535 -> B=16'hFFFF, err=0; value 00000 -> B=16'h0000, err=0, done pulse still produced.
REQ-029 Value 99999 -> with macro: B=16'h0000, err=1; without macro: B=16'h869F, err=0.
REQ-030 BCD_2=4'hA, with macro -> done=1 and err=1 after edge k+1, B=0; a new start is then accepted at edge k+2.
REQ-031 start re-pulsed at edge k+5 with different digits -> ignored; the result matches the first digits.
REQ-032 rst_n pulsed low at cycle k+8 -> B=0 and busy=0 immediately; no done pulse occurs; the next start converts correctly with 17-clock latency.
